sc_stream_decoder: RTL and testbench

SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

---
 rtl/sc_stream_decoder_if.sv | 38 +++
 rtl/sc_stream_decoder.sv | 141 ++++++++++++++
 tb/tb_sc_stream_decoder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// sc_stream_decoder_if
// Bundles the stream, result and status signals of sc_stream_decoder.
//   master : stimulus side. Drives start, bit_valid, bit_in, ref_bit and
//            result_ready. Observes the result and status outputs.
//   slave  : decoder side. Receives the stream and drives busy,
//            result_valid, ones_count, bipolar_est, mismatch_count,
//            tamper_flag and overrun.
// CNT_W must match the CNT_W of the decoder attached to this interface.
// ---------------------------------------------------------------------------
interface sc_stream_decoder_if #(
  parameter int CNT_W = 8
);
  logic                    start;
  logic                    bit_valid;
  logic                    bit_in;
  logic                    ref_bit;
  logic                    result_ready;
  logic                    busy;
  logic                    result_valid;
  logic [CNT_W-1:0]        ones_count;
  logic signed [CNT_W:0]   bipolar_est;
  logic [CNT_W-1:0]        mismatch_count;
  logic                    tamper_flag;
  logic                    overrun;

  modport master (
    output start, bit_valid, bit_in, ref_bit, result_ready,
    input  busy, result_valid, ones_count, bipolar_est, mismatch_count,
           tamper_flag, overrun
  );

  modport slave (
    input  start, bit_valid, bit_in, ref_bit, result_ready,
    output busy, result_valid, ones_count, bipolar_est, mismatch_count,
           tamper_flag, overrun
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// ---------------------------------------------------------------------------
// sc_stream_decoder
// Decodes one window of WINDOW stochastic-computing stream bits. It counts
// the ones in the observed stream and counts the bits that disagree with a
// golden reference stream. At the end of the window it presents the ones
// count, the bipolar estimate and a tamper flag. The result is held until a
// valid/ready handshake completes.
//   clk  : single clock, all state changes on posedge
//   rst  : synchronous, active-high reset
//   bus  : sc_stream_decoder_if.slave
//          start, bit_valid, bit_in, ref_bit, result_ready  (in)
//          busy, result_valid, ones_count, bipolar_est,
//          mismatch_count, tamper_flag, overrun              (out)
// ---------------------------------------------------------------------------
module sc_stream_decoder #(
  parameter int WINDOW        = 128,
  parameter int CNT_W         = $clog2(WINDOW + 1),
  parameter int TAMPER_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_stream_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]    LAST_POS = CNT_W'(WINDOW - 1);
  localparam logic signed [CNT_W:0] WINDOW_S = (CNT_W + 1)'(WINDOW);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] ones_acc;
  logic [CNT_W-1:0] mis_acc;
  logic [CNT_W-1:0] pos;
  logic             clear_cnt;
  logic             accum_en;
  logic             last_bit;
  logic [CNT_W-1:0] ones_final;
  logic [CNT_W-1:0] mis_final;

  // Running totals including the bit presented this cycle. These values are
  // latched into the result registers when the last bit of the window is
  // accepted.
  assign ones_final = ones_acc + CNT_W'(bus.bit_in);
  assign mis_final  = mis_acc + CNT_W'(bus.bit_in ^ bus.ref_bit);

  // NOTE: every signal written here gets a default value first. If a branch
  // left a signal unassigned, synthesis would infer a latch to hold it.
  always_comb begin
    state_next = state;
    clear_cnt  = 1'b0;
    accum_en   = 1'b0;
    last_bit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ACCUM;
          clear_cnt  = 1'b1;
        end
      end
      ACCUM: begin
        // A restart takes priority. The bit offered in the same cycle
        // belongs to neither the old window nor the new one.
        if (bus.start) begin
          clear_cnt = 1'b1;
        end else if (bus.bit_valid) begin
          accum_en = 1'b1;
          if (pos == LAST_POS) begin
            last_bit   = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // A start request is honoured only together with the handshake.
        // On its own it is dropped, not queued.
        if (bus.result_ready) begin
          if (bus.start) begin
            state_next = ACCUM;
            clear_cnt  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // sample their inputs from before the edge, whatever the order in which
  // the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      ones_acc <= '0;
      mis_acc  <= '0;
      pos      <= '0;
    end else if (accum_en) begin
      ones_acc <= ones_final;
      mis_acc  <= mis_final;
      pos      <= last_bit ? '0 : pos + CNT_W'(1);
    end
  end

  // The result registers change only on entry to HOLD. Between windows they
  // keep the last result, which is why they are separate from the
  // accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ones_count     <= '0;
      bus.mismatch_count <= '0;
      bus.bipolar_est    <= -WINDOW_S;
      bus.tamper_flag    <= 1'b0;
    end else if (last_bit) begin
      bus.ones_count     <= ones_final;
      bus.mismatch_count <= mis_final;
      // 2*ones needs at most CNT_W+1 bits, so the signed result
      // 2*ones - WINDOW lies in -WINDOW..+WINDOW without overflow.
      bus.bipolar_est    <= $signed({ones_final, 1'b0}) - WINDOW_S;
      bus.tamper_flag    <= (32'(mis_final) >= TAMPER_THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                   bus.overrun <= 1'b0;
    else if (bus.bit_valid && state != ACCUM)  bus.overrun <= 1'b1;
  end

  assign bus.busy         = (state == ACCUM);
  assign bus.result_valid = (state == HOLD);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_sc_stream_decoder
// The driver sends windows of random stream bits. For each window it
// predicts the result from the whole window with plain population counts
// and queues that prediction. A monitor on the falling clock edge pops the
// prediction when result_valid rises. It checks the latency and the result
// values, and it rechecks the values on every further HOLD cycle.
// ---------------------------------------------------------------------------
module tb_sc_stream_decoder;
  localparam int WINDOW = 128;
  localparam int CNT_W  = 8;
  localparam int THRESH = 4;

  typedef struct {
    longint ones;
    longint mis;
    longint bip;
    longint tamper;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  exp_t   sb_q[$];
  exp_t   cur;
  bit     have_cur = 1'b0;
  bit     prev_rv = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_stream_decoder_if #(.CNT_W(CNT_W)) bus ();

  sc_stream_decoder #(
    .WINDOW(WINDOW),
    .CNT_W(CNT_W),
    .TAMPER_THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: consumes one prediction each time a result is presented.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (!prev_rv) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          have_cur = 1'b0;
          $display("FAIL unexpected_result: result_valid=1 with no result due (t=%0t)", $time);
        end else begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
          check("result_latency_cycle", cyc, cur.cyc);
        end
      end
      if (have_cur) begin
        check("ones_count", longint'(bus.ones_count), cur.ones);
        check("mismatch_count", longint'(bus.mismatch_count), cur.mis);
        check("bipolar_est", longint'($signed(bus.bipolar_est)), cur.bip);
        check("tamper_flag", longint'(bus.tamper_flag), cur.tamper);
      end
    end
    prev_rv = (bus.result_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WINDOW-1:0] rand_vec();
    logic [WINDOW-1:0] v;
    for (int k = 0; k < WINDOW / 32; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: the result of a full window is fixed by the window's
  // bits alone.
  task automatic push_expected(input logic [WINDOW-1:0] b, input logic [WINDOW-1:0] r);
    exp_t e;
    e.ones   = $countones(b);
    e.mis    = $countones(b ^ r);
    e.bip    = 2 * e.ones - WINDOW;
    e.tamper = (e.mis >= THRESH) ? 1 : 0;
    e.cyc    = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic start_pulse();
    bus.start     = 1'b1;
    bus.bit_valid = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  // Sends bits 0..n-1 of b/r. Valid cycles occur with probability pct.
  // A prediction is queued only when a full window is delivered.
  task automatic send_bits(input logic [WINDOW-1:0] b, input logic [WINDOW-1:0] r,
                           input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 8 && int'($urandom_range(99)) >= pct; g++) begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = $urandom_range(1);
        tick();
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = b[i];
      bus.ref_bit   = r[i];
      if (n == WINDOW && i == WINDOW - 1) push_expected(b, r);
      tick();
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic full_window(input logic [WINDOW-1:0] b, input logic [WINDOW-1:0] r,
                             input int pct);
    start_pulse();
    send_bits(b, r, WINDOW, pct);
    repeat (3) tick();
  endtask

  task automatic check_reset_state();
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_result_valid", longint'(bus.result_valid), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    check("rst_tamper_flag", longint'(bus.tamper_flag), 0);
    check("rst_ones_count", longint'(bus.ones_count), 0);
    check("rst_mismatch_count", longint'(bus.mismatch_count), 0);
    check("rst_bipolar_est", longint'($signed(bus.bipolar_est)), -WINDOW);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WINDOW-1:0] b;
    logic [WINDOW-1:0] r;
    logic [WINDOW-1:0] m;

    bus.start        = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.bit_in       = 1'b0;
    bus.ref_bit      = 1'b0;
    bus.result_ready = 1'b1;
    rst              = 1'b1;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;
    tick();

    // Half ones, clean reference stream.
    b = {(WINDOW / 2){2'b10}};
    full_window(b, b, 100);

    // An inverted bit every 8th position gives 16 mismatches.
    b = rand_vec();
    m = '0;
    for (int i = 0; i < WINDOW; i += 8) m[i] = 1'b1;
    full_window(b, b ^ m, 100);

    // All ones; then all zeros against an all-ones reference.
    b = '1;
    full_window(b, b, 100);
    b = '0;
    r = '1;
    full_window(b, r, 100);

    // Tamper threshold boundary: 4 mismatches flag, 3 do not.
    b = rand_vec();
    m = '0;
    m[0] = 1'b1; m[31] = 1'b1; m[64] = 1'b1; m[127] = 1'b1;
    full_window(b, b ^ m, 100);
    m[64] = 1'b0;
    full_window(b, b ^ m, 100);

    // bit_valid gaps and sparse random mismatches.
    for (int w = 0; w < 4; w++) begin
      b = rand_vec();
      m = rand_vec() & rand_vec() & rand_vec();
      full_window(b, b ^ m, 50);
    end

    // Stalled consumer: start and bits in HOLD are ignored, overrun sets.
    bus.result_ready = 1'b0;
    b = rand_vec();
    m = rand_vec() & rand_vec();
    start_pulse();
    send_bits(b, b ^ m, WINDOW, 100);
    for (int k = 0; k < 10; k++) begin
      bus.start     = (k % 3 == 0);
      bus.bit_valid = 1'b1;
      bus.bit_in    = $urandom_range(1);
      tick();
    end
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
    check("hold_result_valid", longint'(bus.result_valid), 1);
    check("hold_overrun", longint'(bus.overrun), 1);
    bus.result_ready = 1'b1;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check("handshake_start_busy", longint'(bus.busy), 1);
    check("handshake_start_result_valid", longint'(bus.result_valid), 0);
    b = rand_vec();
    send_bits(b, b, WINDOW, 100);
    repeat (3) tick();
    check("overrun_sticky", longint'(bus.overrun), 1);

    // Reset in mid-window: reset values, no result, then a clean window.
    b = rand_vec();
    start_pulse();
    send_bits(b, b, 50, 100);
    rst           = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    tick();
    check_reset_state();
    rst           = 1'b0;
    bus.bit_valid = 1'b0;
    tick();
    b = rand_vec();
    m = rand_vec() & rand_vec();
    full_window(b, b ^ m, 100);

    // Restart at bit 100. Only the 128 bits after it count.
    b = '1;
    start_pulse();
    send_bits(b, ~b, 100, 100);
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    bus.ref_bit   = 1'b0;
    tick();
    bus.start = 1'b0;
    b = rand_vec();
    m = rand_vec() & rand_vec() & rand_vec();
    send_bits(b, b ^ m, WINDOW, 50);

    repeat (5) tick();
    check("scoreboard_drained", longint'(sb_q.size()), 0);
    check("final_overrun", longint'(bus.overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
